// File: rtl/cache_help.sv
// Shared cache types: memory word/line widths, operations, and the arbiter's
// FSM state and requester encodings.
package cache_help;

    localparam int WORD_WIDTH = 32;
    localparam int LINE_WIDTH = 128;

    typedef logic [WORD_WIDTH-1:0] Word;
    typedef logic [LINE_WIDTH-1:0] Line;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } MemoryOperation;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } ArbiterState;

    typedef enum logic {
        REQ_INSTRUCTION = 1'b0,
        REQ_DATA        = 1'b1
    } Requester;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way request arbiter: round-robin against the last served port, or a
// fixed data-side preference when fixed_priority is set. Purely combinational.
module rr_arbiter_2
    import cache_help::*;
(
    input  logic     valid_i,
    input  logic     valid_d,
    input  Requester last_served,
    input  logic     fixed_priority,
    output Requester grant,
    output logic     grant_valid
);

    always_comb begin
        grant       = REQ_INSTRUCTION;
        grant_valid = valid_i | valid_d;
        if (valid_i && valid_d) begin
            if (fixed_priority) begin
                grant = REQ_DATA;
            end else begin
                grant = (last_served == REQ_DATA) ? REQ_INSTRUCTION : REQ_DATA;
            end
        end else if (valid_d) begin
            grant = REQ_DATA;
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares one L2 request/response channel between the L1 I-cache and D-cache,
// one transaction in flight; loads route the L2 response back to the owner.
module l2_request_arbiter
    import cache_help::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic           clk_in,
    input  logic           rst_in,

    output logic           i_request_ready_out,
    input  logic           i_request_valid_in,
    input  Word            i_request_address_in,
    input  MemoryOperation i_request_operation_in,
    input  Line            i_request_data_in,
    input  logic           i_response_ready_in,
    output logic           i_response_valid_out,
    output Line            i_response_data_out,

    output logic           d_request_ready_out,
    input  logic           d_request_valid_in,
    input  Word            d_request_address_in,
    input  MemoryOperation d_request_operation_in,
    input  Line            d_request_data_in,
    input  logic           d_response_ready_in,
    output logic           d_response_valid_out,
    output Line            d_response_data_out,

    input  logic           l2_request_ready_in,
    output logic           l2_request_valid_out,
    output Word            l2_request_address_out,
    output MemoryOperation l2_request_operation_out,
    output Line            l2_request_data_out,
    output logic           l2_response_ready_out,
    input  logic           l2_response_valid_in,
    input  Line            l2_response_data_in,

    output ArbiterState    debug_state
);

    // Handshakes on every channel are valid/ready: a transfer happens on a rising
    // edge where both are 1; a source holds valid and payload steady until then.

    ArbiterState    state, state_next;
    Requester       owner, last_served;
    Requester       grant;
    logic           grant_valid;
    Word            address_q;
    MemoryOperation operation_q;
    Line            data_q;

    logic accept_i, accept_d, accept;
    logic owner_response_ready;
    logic response_done;

    rr_arbiter_2 u_rr_arbiter (
        .valid_i        (i_request_valid_in),
        .valid_d        (d_request_valid_in),
        .last_served    (last_served),
        .fixed_priority (FIXED_PRIORITY != 0),
        .grant          (grant),
        .grant_valid    (grant_valid)
    );

    always_comb begin
        accept_i             = (state == IDLE) && grant_valid && (grant == REQ_INSTRUCTION);
        accept_d             = (state == IDLE) && grant_valid && (grant == REQ_DATA);
        accept               = accept_i || accept_d;
        owner_response_ready = (owner == REQ_DATA) ? d_response_ready_in : i_response_ready_in;
        response_done        = (state == WAIT_RESP) && l2_response_valid_in && owner_response_ready;

        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                // Stores finish on L2 acceptance; only loads wait for data.
                if (l2_request_ready_in) state_next = (operation_q == STORE) ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (response_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            owner       <= REQ_INSTRUCTION;
            last_served <= REQ_DATA;
            address_q   <= '0;
            operation_q <= LOAD;
            data_q      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner       <= grant;
                last_served <= grant;
                address_q   <= accept_d ? d_request_address_in   : i_request_address_in;
                operation_q <= accept_d ? d_request_operation_in : i_request_operation_in;
                data_q      <= accept_d ? d_request_data_in      : i_request_data_in;
            end
        end
    end

    // Every valid/ready output is gated by reset so it drops without waiting for a clock.
    always_comb begin
        i_request_ready_out      = !rst_in && accept_i;
        d_request_ready_out      = !rst_in && accept_d;

        l2_request_valid_out     = !rst_in && (state == ISSUE);
        l2_request_address_out   = address_q;
        l2_request_operation_out = operation_q;
        l2_request_data_out      = data_q;

        i_response_valid_out     = !rst_in && (state == WAIT_RESP) && (owner == REQ_INSTRUCTION)
                                   && l2_response_valid_in;
        d_response_valid_out     = !rst_in && (state == WAIT_RESP) && (owner == REQ_DATA)
                                   && l2_response_valid_in;
        l2_response_ready_out    = !rst_in && (state == WAIT_RESP) && owner_response_ready;

        i_response_data_out      = l2_response_data_in;
        d_response_data_out      = l2_response_data_in;

        debug_state              = state;
    end

    // A stalled L2 request must keep presenting the same payload.
    property p_request_stable;
        @(posedge clk_in) disable iff (rst_in)
        (l2_request_valid_out && !l2_request_ready_in) |=>
            (l2_request_valid_out && $stable(address_q) && $stable(operation_q) && $stable(data_q));
    endproperty
    a_request_stable: assert property (p_request_stable);

    a_single_grant: assert property (@(posedge clk_in) disable iff (rst_in)
        !(i_request_ready_out && d_request_ready_out));

endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Shares the single L2 cache request/response channel between the L1 instruction cache and the L1 data cache. It accepts one request at a time from either L1 and forwards it to the L2 unchanged. For loads it routes the L2 response back to the requesting L1; stores complete on L2 acceptance. It sits between the two L1 caches and `l2_cache_bram`, with at most one transaction in flight.

## Interface
- `FIXED_PRIORITY`, default 0: 0 = round-robin between ports; 1 = data port always wins ties.
- `clk_in` in 1: clock; all state updates on rising edge.
- `rst_in` in 1: reset, asynchronous, active-high.
- `i_request_ready_out` out 1; `i_request_valid_in` in 1; `i_request_address_in` in `Word`; `i_request_operation_in` in `MemoryOperation`; `i_request_data_in` in `Line`: instruction-side request channel.
- `i_response_ready_in` in 1; `i_response_valid_out` out 1; `i_response_data_out` out `Line`: instruction-side response channel.
- `d_request_*` / `d_response_*`: data-side channels, identical widths and directions to the `i_` set.
- `l2_request_ready_in` in 1; `l2_request_valid_out` out 1; `l2_request_address_out` out `Word`; `l2_request_operation_out` out `MemoryOperation`; `l2_request_data_out` out `Line`: request channel to L2.
- `l2_response_ready_out` out 1; `l2_response_valid_in` in 1; `l2_response_data_in` in `Line`: response channel from L2.

## Operation
- States: IDLE, ISSUE, WAIT_RESP. Registers: `state`, `owner` (`Requester`), `last_served` (`Requester`), latched address, operation and data.
- Reset: state=IDLE, owner=REQ_INSTRUCTION, last_served=REQ_DATA, latched fields=0. While `rst_in`=1, every valid/ready output is 0.
- IDLE, grant:
  - Only one port valid: grant it.
  - Both valid, `FIXED_PRIORITY`=0: grant the port ≠ `last_served`.
  - Both valid, `FIXED_PRIORITY`=1: grant D.
- IDLE: `x_request_ready_out`=1 only for the granted port. On handshake, latch address/op/data, set owner and last_served to the granted port, go to ISSUE.
- ISSUE: `l2_request_valid_out`=1, driven from the latched fields.
  - `l2_request_ready_in`=1 with op STORE: go to IDLE. The store is complete and produces no L1 response.
  - `l2_request_ready_in`=1 with op LOAD: go to WAIT_RESP.
- WAIT_RESP, combinational pass-through:
  - `owner_response_valid_out` = `l2_response_valid_in`.
  - `owner_response_data_out` = `l2_response_data_in`.
  - `l2_response_ready_out` = `owner_response_ready_in`.
  - When valid and ready are both 1: go to IDLE.
- Non-owner `response_valid_out` is always 0. Both `response_data_out` ports carry `l2_response_data_in` at all times; consumers qualify with valid.
- `l2_response_ready_out`=0 outside WAIT_RESP, so any L2 response in those states is ignored.
- Both request readies are 0 outside IDLE. A requester that holds valid is served in a later IDLE cycle.

## Timing
- Request handshake at edge N; `l2_request_valid_out` high from cycle N+1 (one cycle of arbitration latency).
- STORE occupancy is at least 2 cycles, so the next grant is no earlier than cycle N+2.
- LOAD occupancy is at least 3 cycles: IDLE, then ISSUE, then a WAIT_RESP cycle whose response transfer returns to IDLE.
- Back-to-back requests from both ports with zero L2 wait alternate I, D, I, D in round-robin mode.
- L2 or L1 backpressure holds the FSM in ISSUE or WAIT_RESP indefinitely. Latched fields stay stable while `l2_request_valid_out`=1.
- Reset asserted mid-transaction: immediate return to IDLE and the transaction is dropped. L2 shares this reset.
- No combinational path from `l2_*` inputs to any `x_request_ready_out`.

## Structure
- `cache_help` gains `ArbiterState` (IDLE, ISSUE, WAIT_RESP) and `Requester` (REQ_INSTRUCTION, REQ_DATA).
- `Word`, `Line` and `MemoryOperation` are reused from the existing packages.
- One sub-module, `rr_arbiter_2`: inputs `valid_i`, `valid_d`, `last_served`, `fixed_priority`; outputs `grant` (`Requester`) and `grant_valid`. Purely combinational.

## Test plan
- **I LOAD alone:** I LOAD address 0x100 accepted at edge 0. `l2_request_valid_out`=1 at cycle 1 with address 0x100 and op LOAD. L2 ready at 1, response 0xAB…AB at cycle 3 → `i_response_valid_out`=1 with that data, `d_response_valid_out`=0, state returns to IDLE.
- **Simultaneous, round-robin:** I and D both valid from reset, all STOREs, L2 always ready → grants I, D, I, D on edges 0, 2, 4, 6.
- **Fixed priority:** `FIXED_PRIORITY`=1, both ports constantly valid, L2 always ready → every grant goes to D and I never receives ready.
- **Backpressure:** D LOAD granted, L2 ready low for 5 cycles → request fields are constant and both L1 readies stay 0. Response presented with `d_response_ready_in` low for 3 cycles → `l2_response_ready_out`=0 for those cycles.
- **Stray response:** `l2_response_valid_in`=1 while in IDLE → no L1 `response_valid_out` asserts and `l2_response_ready_out`=0.
- **Reset mid-transaction:** `rst_in` pulsed during WAIT_RESP → all valid/ready outputs go to 0 asynchronously. After release the first grant goes to I when both ports are valid.
